// File: rtl/pcie_flow_ctrl_rx.sv
// rtl/pcie_flow_ctrl_rx.sv - receive-side PCIe DLLP parser and VC0 flow-control credit tracker

// DLLP CRC-16 (polynomial 0x100B) over one 32-bit word, byte 0 first, bit 0 first within each byte
module pcie_datalink_crc (
    input  logic [31:0] data_i,
    input  logic [15:0] crc_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_v;
    logic        fb_v;

    // Bit-serial LFSR unrolled over the whole word
    always_comb begin
        crc_v = crc_i;
        fb_v  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            fb_v  = crc_v[15] ^ data_i[i];
            crc_v = {crc_v[14:0], 1'b0} ^ ({16{fb_v}} & 16'h100B);
        end
        crc_o = crc_v;
    end

endmodule

module pcie_flow_ctrl_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    input  logic                  link_up_i,
    output logic [7:0]            p_hdr_credits_o,
    output logic [7:0]            np_hdr_credits_o,
    output logic [7:0]            cpl_hdr_credits_o,
    output logic [11:0]           p_data_credits_o,
    output logic [11:0]           np_data_credits_o,
    output logic [11:0]           cpl_data_credits_o,
    output logic                  fc1_values_stored_o,
    output logic                  fc2_values_stored_o,
    output logic                  dllp_valid_o,
    output logic                  crc_err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CRC   = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    localparam logic [1:0] FC_INIT1 = 2'd0;
    localparam logic [1:0] FC_INIT2 = 2'd1;
    localparam logic [1:0] FC_DONE  = 2'd2;

    // Parse pipeline state
    logic [1:0]  parse_state_q, parse_state_d;
    logic [31:0] word_q, word_d;
    logic [15:0] crc_q, crc_d;
    logic        dllp_valid_q, dllp_valid_d;
    logic        crc_err_q, crc_err_d;
    logic [15:0] crc_calc;
    logic        beat;

    // Init / credit state
    logic [1:0]  init_state_q, init_state_d;
    logic [2:0]  seen_q, seen_d;
    logic        fc1_q, fc1_d;
    logic        fc2_q, fc2_d;
    logic [7:0]  p_hdr_q, p_hdr_d, np_hdr_q, np_hdr_d, cpl_hdr_q, cpl_hdr_d;
    logic [11:0] p_dat_q, p_dat_d, np_dat_q, np_dat_d, cpl_dat_q, cpl_dat_d;

    // Field decode of the registered beat-1 word
    logic [3:0]  dl_type;
    logic [2:0]  dl_vc;
    logic [7:0]  dl_hdr;
    logic [11:0] dl_data;
    logic [1:0]  dl_cls;
    logic        cls_ok;
    logic        is_init1, is_init2, is_upd;
    logic [2:0]  cls_onehot;
    logic        load;

    logic        unused_inputs;

    // Stream sideband and reserved DLLP bits carry nothing this block needs
    assign unused_inputs = ^{s_axis_tkeep, s_axis_tuser, word_q[3], word_q[15:14], word_q[21:20]};

    assign s_axis_tready = rst_ni;
    assign beat          = s_axis_tvalid & s_axis_tready;

    pcie_datalink_crc u_crc (
        .data_i (s_axis_tdata[31:0]),
        .crc_i  (16'hFFFF),
        .crc_o  (crc_calc)
    );

    assign dl_type  = word_q[7:4];
    assign dl_vc    = word_q[2:0];
    assign dl_hdr   = {word_q[13:8], word_q[23:22]};
    assign dl_data  = {word_q[19:16], word_q[31:24]};
    // Type low bits give the class (P/NP/Cpl), high bits the DLLP kind
    assign dl_cls   = dl_type[1:0];
    assign cls_ok   = (dl_cls != 2'd3);
    assign is_init1 = (dl_type[3:2] == 2'b01) & cls_ok;
    assign is_init2 = (dl_type[3:2] == 2'b11) & cls_ok;
    assign is_upd   = (dl_type[3:2] == 2'b10) & cls_ok;

    // Two-beat framing: capture word plus its CRC on beat 1, compare on beat 2
    always_comb begin
        parse_state_d = parse_state_q;
        word_d        = word_q;
        crc_d         = crc_q;
        dllp_valid_d  = 1'b0;
        crc_err_d     = 1'b0;
        if (!link_up_i) begin
            parse_state_d = ST_IDLE;
        end else if (beat) begin
            case (parse_state_q)
                ST_IDLE: begin
                    if (s_axis_tlast) begin
                        crc_err_d = 1'b1;
                    end else begin
                        word_d        = s_axis_tdata[31:0];
                        crc_d         = crc_calc;
                        parse_state_d = ST_CRC;
                    end
                end
                ST_CRC: begin
                    if (s_axis_tlast) begin
                        if (s_axis_tdata[15:0] == ~crc_q) begin
                            dllp_valid_d = 1'b1;
                        end else begin
                            crc_err_d = 1'b1;
                        end
                        parse_state_d = ST_IDLE;
                    end else begin
                        crc_err_d     = 1'b1;
                        parse_state_d = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (s_axis_tlast) begin
                        parse_state_d = ST_IDLE;
                    end
                end
                default: parse_state_d = ST_IDLE;
            endcase
        end
    end

    // Class one-hot for the seen[] bookkeeping
    always_comb begin
        case (dl_cls)
            2'd0:    cls_onehot = 3'b001;
            2'd1:    cls_onehot = 3'b010;
            2'd2:    cls_onehot = 3'b100;
            default: cls_onehot = 3'b000;
        endcase
    end

    // Flow-control init sequencing; the update lands on the same edge as the dllp_valid pulse
    always_comb begin
        init_state_d = init_state_q;
        seen_d       = seen_q;
        fc1_d        = fc1_q;
        fc2_d        = fc2_q;
        load         = 1'b0;
        p_hdr_d      = p_hdr_q;
        np_hdr_d     = np_hdr_q;
        cpl_hdr_d    = cpl_hdr_q;
        p_dat_d      = p_dat_q;
        np_dat_d     = np_dat_q;
        cpl_dat_d    = cpl_dat_q;

        if (dllp_valid_d && (dl_vc == 3'd0)) begin
            case (init_state_q)
                FC_INIT1: begin
                    if (is_init1 || is_init2) begin
                        load   = 1'b1;
                        seen_d = seen_q | cls_onehot;
                        if (&seen_d) begin
                            fc1_d        = 1'b1;
                            init_state_d = FC_INIT2;
                        end
                    end
                end
                FC_INIT2: begin
                    if (is_init2 || is_upd) begin
                        fc2_d        = 1'b1;
                        init_state_d = FC_DONE;
                        load         = is_upd;
                    end
                end
                FC_DONE: begin
                    load = is_upd;
                end
                default: init_state_d = FC_INIT1;
            endcase
        end

        if (load) begin
            case (dl_cls)
                2'd0: begin
                    p_hdr_d = dl_hdr;
                    p_dat_d = dl_data;
                end
                2'd1: begin
                    np_hdr_d = dl_hdr;
                    np_dat_d = dl_data;
                end
                2'd2: begin
                    cpl_hdr_d = dl_hdr;
                    cpl_dat_d = dl_data;
                end
                default: ;
            endcase
        end

        // Link down restarts initialisation from scratch
        if (!link_up_i) begin
            init_state_d = FC_INIT1;
            seen_d       = 3'b000;
            fc1_d        = 1'b0;
            fc2_d        = 1'b0;
            p_hdr_d      = 8'h00;
            np_hdr_d     = 8'h00;
            cpl_hdr_d    = 8'h00;
            p_dat_d      = 12'h000;
            np_dat_d     = 12'h000;
            cpl_dat_d    = 12'h000;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parse_state_q <= ST_IDLE;
            word_q        <= 32'h0;
            crc_q         <= 16'h0;
            dllp_valid_q  <= 1'b0;
            crc_err_q     <= 1'b0;
            init_state_q  <= FC_INIT1;
            seen_q        <= 3'b000;
            fc1_q         <= 1'b0;
            fc2_q         <= 1'b0;
            p_hdr_q       <= 8'h00;
            np_hdr_q      <= 8'h00;
            cpl_hdr_q     <= 8'h00;
            p_dat_q       <= 12'h000;
            np_dat_q      <= 12'h000;
            cpl_dat_q     <= 12'h000;
        end else begin
            parse_state_q <= parse_state_d;
            word_q        <= word_d;
            crc_q         <= crc_d;
            dllp_valid_q  <= dllp_valid_d;
            crc_err_q     <= crc_err_d;
            init_state_q  <= init_state_d;
            seen_q        <= seen_d;
            fc1_q         <= fc1_d;
            fc2_q         <= fc2_d;
            p_hdr_q       <= p_hdr_d;
            np_hdr_q      <= np_hdr_d;
            cpl_hdr_q     <= cpl_hdr_d;
            p_dat_q       <= p_dat_d;
            np_dat_q      <= np_dat_d;
            cpl_dat_q     <= cpl_dat_d;
        end
    end

    assign dllp_valid_o        = dllp_valid_q;
    assign crc_err_o           = crc_err_q;
    assign fc1_values_stored_o = fc1_q;
    assign fc2_values_stored_o = fc2_q;
    assign p_hdr_credits_o     = p_hdr_q;
    assign np_hdr_credits_o    = np_hdr_q;
    assign cpl_hdr_credits_o   = cpl_hdr_q;
    assign p_data_credits_o    = p_dat_q;
    assign np_data_credits_o   = np_dat_q;
    assign cpl_data_credits_o  = cpl_dat_q;

endmodule

// File: tb/tb_pcie_flow_ctrl_rx.sv
// tb/tb_pcie_flow_ctrl_rx.sv - directed vector bench for pcie_flow_ctrl_rx
module tb_pcie_flow_ctrl_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic [2:0]  tuser;
    logic        tready;
    logic        link_up;
    logic [7:0]  p_hdr, np_hdr, cpl_hdr;
    logic [11:0] p_dat, np_dat, cpl_dat;
    logic        fc1, fc2, dvalid, cerr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcie_flow_ctrl_rx dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .s_axis_tdata        (tdata),
        .s_axis_tkeep        (tkeep),
        .s_axis_tvalid       (tvalid),
        .s_axis_tlast        (tlast),
        .s_axis_tuser        (tuser),
        .s_axis_tready       (tready),
        .link_up_i           (link_up),
        .p_hdr_credits_o     (p_hdr),
        .np_hdr_credits_o    (np_hdr),
        .cpl_hdr_credits_o   (cpl_hdr),
        .p_data_credits_o    (p_dat),
        .np_data_credits_o   (np_dat),
        .cpl_data_credits_o  (cpl_dat),
        .fc1_values_stored_o (fc1),
        .fc2_values_stored_o (fc2),
        .dllp_valid_o        (dvalid),
        .crc_err_o           (cerr)
    );

    typedef struct packed {
        logic [3:0]  typ;
        logic [2:0]  vc;
        logic [7:0]  hdr;
        logic [11:0] dat;
        logic [15:0] flip;
        logic        e_valid;
        logic        e_err;
        logic        e_fc1;
        logic        e_fc2;
        logic [7:0]  e_ph;
        logic [11:0] e_pd;
        logic [7:0]  e_nh;
        logic [11:0] e_nd;
        logic [7:0]  e_ch;
        logic [11:0] e_cd;
    } vec_t;

    vec_t vecs [11];

    // Reference CRC-16, polynomial 0x100B, seed all-ones, byte 0 bit 0 first
    function automatic logic [15:0] crc_model(input logic [31:0] w);
        logic [15:0] r;
        logic [7:0]  b;
        r = 16'hFFFF;
        for (int n = 0; n < 4; n++) begin
            b = w[8*n +: 8];
            for (int k = 0; k < 8; k++) begin
                if (r[15] ^ b[k]) r = {r[14:0], 1'b0} ^ 16'h100B;
                else              r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mk_word(input logic [3:0] typ, input logic [2:0] vc,
                                            input logic [7:0] hdr, input logic [11:0] dat);
        logic [7:0] b0, b1, b2, b3;
        b0 = {typ, 1'b0, vc};
        b1 = {2'b00, hdr[7:2]};
        b2 = {hdr[1:0], 2'b00, dat[11:8]};
        b3 = dat[7:0];
        return {b3, b2, b1, b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic ee, input logic ef1, input logic ef2,
                           input logic [7:0] ph, input logic [11:0] pd, input logic [7:0] nh,
                           input logic [11:0] nd, input logic [7:0] ch, input logic [11:0] cd);
        chk({tag, ".dllp_valid"}, {31'b0, dvalid}, {31'b0, ev});
        chk({tag, ".crc_err"},    {31'b0, cerr},   {31'b0, ee});
        chk({tag, ".fc1"},        {31'b0, fc1},    {31'b0, ef1});
        chk({tag, ".fc2"},        {31'b0, fc2},    {31'b0, ef2});
        chk({tag, ".p_hdr"},      {24'b0, p_hdr},  {24'b0, ph});
        chk({tag, ".p_data"},     {20'b0, p_dat},  {20'b0, pd});
        chk({tag, ".np_hdr"},     {24'b0, np_hdr}, {24'b0, nh});
        chk({tag, ".np_data"},    {20'b0, np_dat}, {20'b0, nd});
        chk({tag, ".cpl_hdr"},    {24'b0, cpl_hdr}, {24'b0, ch});
        chk({tag, ".cpl_data"},   {20'b0, cpl_dat}, {20'b0, cd});
    endtask

    // Drives both beats; returns at the falling edge where the result pulse is visible
    task automatic send_dllp(input logic [31:0] w, input logic [15:0] flip);
        @(negedge clk);
        tdata  = w;
        tvalid = 1'b1;
        tlast  = 1'b0;
        @(negedge clk);
        tdata  = {16'h0, ~crc_model(w) ^ flip};
        tlast  = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = 32'h0;
    endtask

    initial begin
        //            typ    vc    hdr    dat      flip     v     e     f1    f2    ph     pd       nh     nd       ch     cd
        vecs[0]  = {4'h4, 3'd0, 8'h20, 12'h010, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 12'h010, 8'h00, 12'h000, 8'h00, 12'h000};
        vecs[1]  = {4'h4, 3'd0, 8'h33, 12'h055, 16'h1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 12'h010, 8'h00, 12'h000, 8'h00, 12'h000};
        vecs[2]  = {4'h9, 3'd0, 8'h11, 12'h022, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 12'h010, 8'h00, 12'h000, 8'h00, 12'h000};
        vecs[3]  = {4'h5, 3'd0, 8'h20, 12'h000, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 12'h010, 8'h20, 12'h000, 8'h00, 12'h000};
        vecs[4]  = {4'h6, 3'd1, 8'h44, 12'h044, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 12'h010, 8'h20, 12'h000, 8'h00, 12'h000};
        vecs[5]  = {4'h6, 3'd0, 8'h20, 12'h010, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 12'h010, 8'h20, 12'h000, 8'h20, 12'h010};
        vecs[6]  = {4'hC, 3'd0, 8'h7F, 12'h7FF, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 12'h010, 8'h20, 12'h000, 8'h20, 12'h010};
        vecs[7]  = {4'hA, 3'd0, 8'h08, 12'h040, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 12'h010, 8'h20, 12'h000, 8'h08, 12'h040};
        vecs[8]  = {4'h4, 3'd0, 8'h55, 12'h555, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 12'h010, 8'h20, 12'h000, 8'h08, 12'h040};
        vecs[9]  = {4'h8, 3'd0, 8'h00, 12'h000, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 12'h000, 8'h20, 12'h000, 8'h08, 12'h040};
        vecs[10] = {4'h0, 3'd0, 8'h12, 12'h345, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 12'h000, 8'h20, 12'h000, 8'h08, 12'h040};

        rst_n   = 1'b0;
        tdata   = 32'h0;
        tkeep   = 4'hF;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        tuser   = 3'b0;
        link_up = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk("reset.tready", {31'b0, tready}, 32'd0);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("run.tready", {31'b0, tready}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            send_dllp(mk_word(vecs[i].typ, vecs[i].vc, vecs[i].hdr, vecs[i].dat), vecs[i].flip);
            chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_err, vecs[i].e_fc1, vecs[i].e_fc2,
                    vecs[i].e_ph, vecs[i].e_pd, vecs[i].e_nh, vecs[i].e_nd, vecs[i].e_ch, vecs[i].e_cd);
        end
        @(negedge clk);
        chk("pulse_one_cycle", {31'b0, dvalid}, 32'd0);

        // Link down for one cycle clears flags and credits
        link_up = 1'b0;
        @(negedge clk);
        link_up = 1'b1;
        chk_all("linkdown", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000);

        // Single-beat packet, then a good DLLP
        @(negedge clk);
        tdata  = 32'hDEADBEEF;
        tvalid = 1'b1;
        tlast  = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        chk("single.crc_err", {31'b0, cerr},   32'd1);
        chk("single.valid",   {31'b0, dvalid}, 32'd0);
        send_dllp(mk_word(4'h4, 3'd0, 8'h20, 12'h010), 16'h0);
        chk_all("after_single", 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 12'h010, 8'h00, 12'h000, 8'h00, 12'h000);

        // Three-beat packet: error on beat 2, drop until tlast
        @(negedge clk);
        tdata  = mk_word(4'h5, 3'd0, 8'h66, 12'h066);
        tvalid = 1'b1;
        tlast  = 1'b0;
        @(negedge clk);
        tdata  = {16'h0, ~crc_model(mk_word(4'h5, 3'd0, 8'h66, 12'h066))};
        @(negedge clk);
        chk("3beat.crc_err", {31'b0, cerr},   32'd1);
        chk("3beat.valid",   {31'b0, dvalid}, 32'd0);
        tdata = 32'h0;
        tlast = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
        chk("drop.crc_err", {31'b0, cerr},   32'd0);
        chk("drop.valid",   {31'b0, dvalid}, 32'd0);
        chk("drop.np_hdr",  {24'b0, np_hdr}, 32'h0);
        send_dllp(mk_word(4'h5, 3'd0, 8'h21, 12'h003), 16'h0);
        chk_all("after_drop", 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 12'h010, 8'h21, 12'h003, 8'h00, 12'h000);

        // DLLP completing while link is down is dropped
        @(negedge clk);
        tdata  = mk_word(4'h6, 3'd0, 8'h30, 12'h030);
        tvalid = 1'b1;
        tlast  = 1'b0;
        @(negedge clk);
        tdata   = {16'h0, ~crc_model(mk_word(4'h6, 3'd0, 8'h30, 12'h030))};
        tlast   = 1'b1;
        link_up = 1'b0;
        @(negedge clk);
        tvalid  = 1'b0;
        tlast   = 1'b0;
        link_up = 1'b1;
        chk_all("linkdrop", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000);
        send_dllp(mk_word(4'h6, 3'd0, 8'h30, 12'h030), 16'h0);
        chk_all("after_linkdrop", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 8'h00, 12'h000, 8'h30, 12'h030);

        // Reset in the middle of a DLLP discards the partial
        @(negedge clk);
        tdata  = mk_word(4'h4, 3'd0, 8'h40, 12'h040);
        tvalid = 1'b1;
        tlast  = 1'b0;
        @(negedge clk);
        tvalid = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst.tready", {31'b0, tready}, 32'd0);
        @(negedge clk);
        chk_all("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 8'h00, 12'h000, 8'h00, 12'h000);
        rst_n = 1'b1;
        send_dllp(mk_word(4'h4, 3'd0, 8'h40, 12'h040), 16'h0);
        chk_all("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 12'h040, 8'h00, 12'h000, 8'h00, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcie_flow_ctrl_rx.md
PCIE_FLOW_CTRL_RX -- requirements
Module: pcie_flow_ctrl_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXIS data width in bits; only 32 is supported.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, AXIS byte-keep width.
REQ-003 SHALL have parameter USER_WIDTH, default 3, AXIS user width; tuser is ignored.
REQ-004 Port clk_i, input, 1: the single clock; all logic is on the rising edge.
REQ-005 Port rst_ni, input, 1: asynchronous reset, active-low.
REQ-006 Port s_axis_tdata/tkeep/tvalid/tlast/tuser, input, DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH: received-DLLP stream.
REQ-007 Port s_axis_tready, output, 1: stream ready.
REQ-008 Port link_up_i, input, 1: data-link up; low restarts flow-control init.
REQ-009 Port p_hdr_credits_o/np_hdr_credits_o/cpl_hdr_credits_o, output, 8 each: advertised HdrFC per class.
REQ-010 Port p_data_credits_o/np_data_credits_o/cpl_data_credits_o, output, 12 each: advertised DataFC per class.
REQ-011 Port fc1_values_stored_o, output, 1: level; all three VC0 InitFC1 values recorded.
REQ-012 Port fc2_values_stored_o, output, 1: level; FC_INIT2 complete.
REQ-013 Port dllp_valid_o, output, 1: one-cycle pulse per DLLP with good CRC.
REQ-014 Port crc_err_o, output, 1: one-cycle pulse per bad-CRC or malformed DLLP.

Function
REQ-015 s_axis_tready SHALL be 1 whenever rst_ni is high; the block never backpressures.
REQ-016 A DLLP SHALL be two beats: beat 1 = 4 DLLP bytes (byte n at tdata[8n+7:8n]), tlast=0; beat 2 = tdata[15:0] CRC, tlast=1.
REQ-017 Field decode: type = byte0[7:4]; VC = byte0[2:0]; HdrFC = {byte1[5:0], byte2[7:6]}; DataFC = {byte2[3:0], byte3}.
REQ-018 Type codes: InitFC1 P/NP/Cpl = 4/5/6; InitFC2 = C/D/E; UpdateFC = 8/9/A; all other codes are accepted, CRC-checked, and then ignored.
REQ-019 The CRC check SHALL pass when beat-2 tdata[15:0] equals the bitwise inverse of the pcie_datalink_crc output (crcIn all-ones) computed over beat-1 tdata.
REQ-020 The parse FSM SHALL have states ST_IDLE, ST_CRC and ST_DROP; the reset state is ST_IDLE.
REQ-021 ST_IDLE: on an accepted beat with tlast=0, register the word and its CRC, then go to ST_CRC; with tlast=1, pulse crc_err_o and stay in ST_IDLE.
REQ-022 ST_CRC, accepted beat with tlast=1: evaluate the CRC and go to ST_IDLE.
REQ-023 ST_CRC, accepted beat with tlast=0: pulse crc_err_o and go to ST_DROP.
REQ-024 ST_DROP SHALL discard beats until one with tlast=1 is accepted, then return to ST_IDLE.
REQ-025 A good CRC SHALL pulse dllp_valid_o, and a bad CRC SHALL pulse crc_err_o, in the cycle after the CRC beat is accepted.
REQ-026 Credit/flag updates SHALL occur in the same cycle as dllp_valid_o; DLLPs with VC!=0 pulse dllp_valid_o but update nothing.
REQ-027 The init FSM SHALL have states FC_INIT1, FC_INIT2 and FC_DONE; the reset state is FC_INIT1.
REQ-028 FC_INIT1: a good InitFC1 or InitFC2 for class X SHALL load X hdr/data credits and set seen[X]; repeats overwrite.
REQ-029 FC_INIT1: once seen[P], seen[NP] and seen[Cpl] are all set, fc1_values_stored_o=1 and the FSM goes to FC_INIT2.
REQ-030 FC_INIT2: InitFC1/InitFC2 values SHALL NOT change credits.
REQ-031 FC_INIT2: a good InitFC2 or UpdateFC (any class) SHALL set fc2_values_stored_o=1 and move to FC_DONE; an UpdateFC also loads its class credits.
REQ-032 UpdateFC in FC_INIT1 SHALL be ignored.
REQ-033 FC_DONE: UpdateFC SHALL overwrite its class credits; Init DLLPs are ignored.
REQ-034 link_up_i low (synchronous) SHALL force FC_INIT1, clear seen[], both flags and all credits, and force the parse FSM to ST_IDLE.
REQ-035 A DLLP completing in a cycle where link_up_i is low SHALL be dropped without pulsing dllp_valid_o.
REQ-036 A zero HdrFC or DataFC value means infinite credit and SHALL be stored as-is, with no special handling.

Reset
REQ-037 While rst_ni is low: all credits 0, fc1/fc2 flags 0, pulses 0, s_axis_tready 0, parse FSM ST_IDLE, init FSM FC_INIT1.
REQ-038 Reset asserted mid-DLLP SHALL discard the partial DLLP; the first beat after release is treated as beat 1.

Verification
REQ-039 Scenario: InitFC1 P (Hdr 0x20, Data 0x010), then NP (0x20, 0x000), then Cpl (0x20, 0x010), all with good CRC -> fc1_values_stored_o=1 in the cycle after the Cpl CRC beat, and credits match.
REQ-040 Scenario: after REQ-039, InitFC2 P with Hdr 0x7F -> fc2_values_stored_o=1 and p_hdr_credits_o remains 0x20.
REQ-041 Scenario: InitFC1 P with CRC bit 0 flipped -> one crc_err_o pulse, no dllp_valid_o, p credits unchanged.
REQ-042 Scenario: single-beat packet with tlast=1 -> crc_err_o pulse; a following good DLLP parses normally.
REQ-043 Scenario: 3-beat packet -> crc_err_o pulse, ST_DROP until tlast, then the next good DLLP is accepted.
REQ-044 Scenario: in FC_DONE, UpdateFC Cpl (0x08, 0x040) -> cpl credits = 0x08/0x040; then link_up_i low for 1 cycle -> flags and credits are 0.
